// File: rtl/axi4_mem_test_scheduler.sv
// axi4_mem_test_scheduler
// Runs one LPDDR4 memory-test pass per start: a write phase through the AXI4
// write sequencer, then a read-back phase through the AXI4 read sequencer.
// Every read beat is compared against the seed-derived pattern. Pass, fail,
// timeout, error count and first-failure status are accumulated for the ILA and LEDs.
// Ports:
//   iCLK, iRST                 clock, asynchronous active-high reset
//   iStart, iStop, iLoop       control levels (rising iStart starts a pass)
//   iSeed                      pattern seed, captured when a pass starts
//   oWrEnable, iWrBurstDone    write sequencer enable / burst-complete pulse
//   oRdEnable, iRdata, iRvalid read sequencer enable / beat data / beat strobe
//   oBusy, oPass, oFail, oTimeout, oErrCount, oPassCount, oFirstErrBeat  status
module axi4_mem_test_scheduler #(
  parameter int pAxi4BusWidth = 512,
  parameter int pDataBitWidth = 16,
  parameter int pDdrBurstSize = 16,
  parameter int pBurstCount   = 1024,
  parameter int pTimeout      = 65535
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iStart,
  input  logic                     iStop,
  input  logic                     iLoop,
  input  logic [pDataBitWidth-1:0] iSeed,
  output logic                     oWrEnable,
  input  logic                     iWrBurstDone,
  output logic                     oRdEnable,
  input  logic [pAxi4BusWidth-1:0] iRdata,
  input  logic                     iRvalid,
  output logic                     oBusy,
  output logic                     oPass,
  output logic                     oFail,
  output logic                     oTimeout,
  output logic [15:0]              oErrCount,
  output logic [15:0]              oPassCount,
  output logic [31:0]              oFirstErrBeat
);

  localparam int          cLanes       = pAxi4BusWidth / pDataBitWidth;
  localparam logic [15:0] cLastBurst   = 16'(pBurstCount - 1);
  localparam logic [31:0] cLastBeat    = 32'(pBurstCount * pDdrBurstSize - 1);
  localparam logic [15:0] cLastInBurst = 16'(pDdrBurstSize - 1);
  localparam logic [19:0] cWdLast      = 20'(pTimeout - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_CHK   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                   state_r, next_state_s;
  logic                     start_d_r, start_rise_s;
  logic [pDataBitWidth-1:0] seed_r, expected_s;
  logic [15:0]              burst_cnt_r, beat_in_burst_r;
  logic [31:0]              beat_cnt_r;
  logic [19:0]              wd_cnt_r;
  logic                     wd_expire_s, chk_cnt_r, drain_from_rd_r;
  logic                     capture_seed_s, clear_status_s, set_pass_s, set_fail_s, set_timeout_s;
  logic                     load_drain_s, drain_rd_s, mismatch_s;
  logic                     mis_valid_r, mismatch_r;
  logic [31:0]              mis_beat_r;
  logic                     wr_en_r, rd_en_r, busy_r, pass_r, fail_r, timeout_r;
  logic [15:0]              err_cnt_r, pass_cnt_r;
  logic [31:0]              first_err_r;

  assign start_rise_s = iStart & ~start_d_r;
  // A burst or beat in the expiry cycle counts as activity, so it always wins.
  assign wd_expire_s  = (wd_cnt_r == cWdLast) & ~iWrBurstDone & ~iRvalid;
  assign expected_s   = seed_r + beat_cnt_r[pDataBitWidth-1:0];

  // Lane-wise compare of the current read beat against the expected pattern.
  always_comb begin
    mismatch_s = 1'b0;
    for (int i = 0; i < cLanes; i++) begin
      if (iRdata[i*pDataBitWidth +: pDataBitWidth] != expected_s) begin
        mismatch_s = 1'b1;
      end else begin
        mismatch_s = mismatch_s;
      end
    end
  end

  // Next-state and one-cycle control strobes.
  always_comb begin
    next_state_s   = state_r;
    capture_seed_s = 1'b0;
    clear_status_s = 1'b0;
    set_pass_s     = 1'b0;
    set_fail_s     = 1'b0;
    set_timeout_s  = 1'b0;
    load_drain_s   = 1'b0;
    drain_rd_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // iStop outranks iStart in the same cycle.
        if (start_rise_s && !iStop) begin
          next_state_s   = ST_WR;
          capture_seed_s = 1'b1;
          clear_status_s = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_WR: begin
        if (iStop) begin
          next_state_s = ST_DRAIN;
          load_drain_s = 1'b1;
          drain_rd_s   = 1'b0;
        end else if (iWrBurstDone && (burst_cnt_r == cLastBurst)) begin
          next_state_s = ST_RD;
        end else if (wd_expire_s) begin
          next_state_s  = ST_DONE;
          set_fail_s    = 1'b1;
          set_timeout_s = 1'b1;
        end else begin
          next_state_s = ST_WR;
        end
      end
      ST_RD: begin
        if (iStop) begin
          next_state_s = ST_DRAIN;
          load_drain_s = 1'b1;
          drain_rd_s   = 1'b1;
        end else if (iRvalid && (beat_cnt_r == cLastBeat)) begin
          next_state_s = ST_CHK;
        end else if (wd_expire_s) begin
          next_state_s  = ST_DONE;
          set_fail_s    = 1'b1;
          set_timeout_s = 1'b1;
        end else begin
          next_state_s = ST_RD;
        end
      end
      ST_CHK: begin
        // Second CHK cycle: the compare pipeline has fully drained into err_cnt_r.
        if (chk_cnt_r) begin
          if (err_cnt_r == 16'd0) begin
            set_pass_s = 1'b1;
            if (iLoop) begin
              next_state_s   = ST_WR;
              capture_seed_s = 1'b1;
            end else begin
              next_state_s = ST_DONE;
            end
          end else begin
            set_fail_s   = 1'b1;
            next_state_s = ST_DONE;
          end
        end else begin
          next_state_s = ST_CHK;
        end
      end
      ST_DRAIN: begin
        if (drain_from_rd_r ? (iRvalid && (beat_in_burst_r == cLastInBurst)) : iWrBurstDone) begin
          next_state_s = ST_IDLE;
        end else if (wd_expire_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register, start-edge detector, registered enables and seed capture.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r         <= ST_IDLE;
      start_d_r       <= 1'b0;
      seed_r          <= '0;
      drain_from_rd_r <= 1'b0;
      wr_en_r         <= 1'b0;
      rd_en_r         <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      start_d_r <= iStart;
      if (capture_seed_s) seed_r <= iSeed;
      if (load_drain_s) drain_from_rd_r <= drain_rd_s;
      wr_en_r <= (next_state_s == ST_WR);
      rd_en_r <= (next_state_s == ST_RD);
      busy_r  <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
    end
  end

  // Burst, beat, watchdog and CHK-wait counters.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      burst_cnt_r     <= 16'd0;
      beat_cnt_r      <= 32'd0;
      beat_in_burst_r <= 16'd0;
      wd_cnt_r        <= 20'd0;
      chk_cnt_r       <= 1'b0;
    end else begin
      if (next_state_s == ST_WR && state_r != ST_WR) begin
        burst_cnt_r     <= 16'd0;
        beat_cnt_r      <= 32'd0;
        beat_in_burst_r <= 16'd0;
      end else begin
        if (state_r == ST_WR && iWrBurstDone) begin
          burst_cnt_r <= (burst_cnt_r == cLastBurst) ? 16'd0 : burst_cnt_r + 16'd1;
        end
        // Beats are still tracked while draining so the burst boundary is visible.
        if ((state_r == ST_RD || (state_r == ST_DRAIN && drain_from_rd_r)) && iRvalid) begin
          beat_cnt_r      <= beat_cnt_r + 32'd1;
          beat_in_burst_r <= (beat_in_burst_r == cLastInBurst) ? 16'd0 : beat_in_burst_r + 16'd1;
        end
      end
      if ((next_state_s != state_r) || iWrBurstDone || iRvalid) begin
        wd_cnt_r <= 20'd0;
      end else if (state_r == ST_WR || state_r == ST_RD || state_r == ST_DRAIN) begin
        wd_cnt_r <= wd_cnt_r + 20'd1;
      end
      chk_cnt_r <= (state_r == ST_CHK) ? ~chk_cnt_r : 1'b0;
    end
  end

  // Compare pipeline stage 1 and accumulated status.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mis_valid_r <= 1'b0;
      mismatch_r  <= 1'b0;
      mis_beat_r  <= 32'd0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      timeout_r   <= 1'b0;
      err_cnt_r   <= 16'd0;
      first_err_r <= 32'd0;
      pass_cnt_r  <= 16'd0;
    end else begin
      mis_valid_r <= (state_r == ST_RD) && iRvalid;
      mismatch_r  <= mismatch_s;
      mis_beat_r  <= beat_cnt_r;
      if (clear_status_s) begin
        pass_r      <= 1'b0;
        fail_r      <= 1'b0;
        timeout_r   <= 1'b0;
        err_cnt_r   <= 16'd0;
        first_err_r <= 32'd0;
      end else begin
        if (mis_valid_r && mismatch_r) begin
          if (err_cnt_r == 16'd0) first_err_r <= mis_beat_r;
          if (err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
        end
        if (set_pass_s) pass_r <= 1'b1;
        if (set_fail_s) fail_r <= 1'b1;
        if (set_timeout_s) timeout_r <= 1'b1;
      end
      if (set_pass_s) pass_cnt_r <= pass_cnt_r + 16'd1;
    end
  end

  assign oWrEnable     = wr_en_r;
  assign oRdEnable     = rd_en_r;
  assign oBusy         = busy_r;
  assign oPass         = pass_r;
  assign oFail         = fail_r;
  assign oTimeout      = timeout_r;
  assign oErrCount     = err_cnt_r;
  assign oPassCount    = pass_cnt_r;
  assign oFirstErrBeat = first_err_r;

endmodule

// File: tb/tb_axi4_mem_test_scheduler.sv
module tb_axi4_mem_test_scheduler;

  localparam int cBus     = 128;
  localparam int cW       = 16;
  localparam int cLanes   = cBus / cW;
  localparam int cBurst   = 16;
  localparam int cBursts  = 4;
  localparam int cTimeout = 100;
  localparam int cBeats   = cBursts * cBurst;

  logic            iCLK, iRST, iStart, iStop, iLoop, iWrBurstDone, iRvalid;
  logic [cW-1:0]   iSeed;
  logic [cBus-1:0] iRdata;
  logic            oWrEnable, oRdEnable, oBusy, oPass, oFail, oTimeout;
  logic [15:0]     oErrCount, oPassCount;
  logic [31:0]     oFirstErrBeat;

  axi4_mem_test_scheduler #(
    .pAxi4BusWidth(cBus), .pDataBitWidth(cW), .pDdrBurstSize(cBurst),
    .pBurstCount(cBursts), .pTimeout(cTimeout)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iStop(iStop), .iLoop(iLoop),
    .iSeed(iSeed), .oWrEnable(oWrEnable), .iWrBurstDone(iWrBurstDone),
    .oRdEnable(oRdEnable), .iRdata(iRdata), .iRvalid(iRvalid), .oBusy(oBusy),
    .oPass(oPass), .oFail(oFail), .oTimeout(oTimeout), .oErrCount(oErrCount),
    .oPassCount(oPassCount), .oFirstErrBeat(oFirstErrBeat)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: status expected after each pass, plus the corruption plan.
  bit          m_pass, m_fail, m_timeout;
  int          m_err, m_first, m_pass_cnt;
  bit          corrupt_en[cBeats];
  int          corrupt_lane[cBeats];
  logic [15:0] corrupt_xor[cBeats];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_corrupt();
    for (int n = 0; n < cBeats; n++) begin
      corrupt_en[n] = 1'b0;
      corrupt_lane[n] = 0;
      corrupt_xor[n] = 16'h0000;
    end
  endtask

  task automatic add_corrupt(input int n, input int lane);
    corrupt_en[n] = 1'b1;
    corrupt_lane[n] = lane;
    corrupt_xor[n] = 16'($urandom_range(1, 65535));
  endtask

  function automatic logic [cBus-1:0] beat_data(input logic [15:0] seed, input int n);
    logic [cBus-1:0] d;
    logic [15:0] lane;
    lane = seed + 16'(n);
    for (int i = 0; i < cLanes; i++) d[i*cW +: cW] = lane;
    if (corrupt_en[n]) d[corrupt_lane[n]*cW +: cW] = lane ^ corrupt_xor[n];
    return d;
  endfunction

  task automatic send_beat(input logic [15:0] seed, input int n);
    repeat ($urandom_range(0, 3)) tick();
    iRdata = beat_data(seed, n);
    iRvalid = 1'b1;
    tick();
    iRvalid = 1'b0;
  endtask

  task automatic send_burst();
    repeat ($urandom_range(0, 4)) tick();
    iWrBurstDone = 1'b1;
    tick();
    iWrBurstDone = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check_value({tag, "_pass"}, 32'(oPass), 32'(m_pass));
    check_value({tag, "_fail"}, 32'(oFail), 32'(m_fail));
    check_value({tag, "_timeout"}, 32'(oTimeout), 32'(m_timeout));
    check_value({tag, "_errcount"}, 32'(oErrCount), 32'(m_err));
    check_value({tag, "_firsterr"}, oFirstErrBeat, 32'(m_first));
    check_value({tag, "_passcount"}, 32'(oPassCount), 32'(m_pass_cnt));
  endtask

  task automatic start_pass(input logic [15:0] seed);
    iSeed = seed;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    m_pass = 1'b0; m_fail = 1'b0; m_timeout = 1'b0; m_err = 0; m_first = 0;
    check_value("start_wr_en", 32'(oWrEnable), 32'd1);
    check_value("start_rd_en", 32'(oRdEnable), 32'd0);
  endtask

  task automatic do_writes();
    for (int b = 0; b < cBursts; b++) send_burst();
    check_value("wr_done_wr_en", 32'(oWrEnable), 32'd0);
    check_value("wr_done_rd_en", 32'(oRdEnable), 32'd1);
  endtask

  task automatic end_pass(input string tag, input logic [15:0] next_seed, input bit loop);
    int errs;
    check_value({tag, "_rd_en_drop"}, 32'(oRdEnable), 32'd0);
    check_value({tag, "_busy_chk"}, 32'(oBusy), 32'd1);
    iSeed = next_seed;
    iLoop = loop;
    tick();
    tick();
    errs = 0;
    for (int n = 0; n < cBeats; n++) begin
      if (corrupt_en[n]) begin
        if (errs == 0) m_first = n;
        errs++;
      end
    end
    m_err = errs;
    if (errs == 0) begin
      m_pass = 1'b1;
      m_pass_cnt = (m_pass_cnt + 1) % 65536;
    end else begin
      m_fail = 1'b1;
    end
    check_status(tag);
    if (errs == 0 && loop) check_value({tag, "_loop_wr_en"}, 32'(oWrEnable), 32'd1);
    else check_value({tag, "_busy_done"}, 32'(oBusy), 32'd0);
  endtask

  task automatic full_pass(input string tag, input logic [15:0] seed, input logic [15:0] next_seed,
                           input bit loop, input bit do_start);
    if (do_start) start_pass(seed);
    do_writes();
    for (int n = 0; n < cBeats; n++) send_beat(seed, n);
    end_pass(tag, next_seed, loop);
  endtask

  task automatic count_wr_window(input string tag);
    int cnt;
    cnt = 0;
    while (oWrEnable && cnt < 300) begin
      tick();
      cnt++;
    end
    m_timeout = 1'b1;
    m_fail = 1'b1;
    check_value({tag, "_cycles"}, 32'(cnt), 32'(cTimeout));
    check_status(tag);
    check_value({tag, "_rd_en"}, 32'(oRdEnable), 32'd0);
    check_value({tag, "_busy"}, 32'(oBusy), 32'd0);
  endtask

  initial begin
    logic [15:0] s0, s1, s2;
    iRST = 1'b1; iStart = 1'b0; iStop = 1'b0; iLoop = 1'b0; iSeed = 16'h0000;
    iWrBurstDone = 1'b0; iRvalid = 1'b0; iRdata = '0;
    m_pass = 1'b0; m_fail = 1'b0; m_timeout = 1'b0; m_err = 0; m_first = 0; m_pass_cnt = 0;
    clear_corrupt();
    repeat (3) tick();
    iRST = 1'b0;
    tick();
    check_status("reset");
    check_value("reset_busy", 32'(oBusy), 32'd0);
    check_value("reset_wr_en", 32'(oWrEnable), 32'd0);
    check_value("reset_rd_en", 32'(oRdEnable), 32'd0);

    // Stop outranks a simultaneous start edge in IDLE.
    iStop = 1'b1; iStart = 1'b1;
    tick();
    check_value("stop_over_start_busy", 32'(oBusy), 32'd0);
    iStop = 1'b0; iStart = 1'b0;
    tick();

    full_pass("clean", 16'h1234, 16'h0000, 1'b0, 1'b1);

    clear_corrupt();
    add_corrupt(37, 3);
    full_pass("lane3_beat37", 16'hBEEF, 16'h0000, 1'b0, 1'b1);

    clear_corrupt();
    add_corrupt(5, $urandom_range(0, cLanes - 1));
    add_corrupt(9, $urandom_range(0, cLanes - 1));
    full_pass("beats5_9", 16'hFFF0, 16'h0000, 1'b0, 1'b1);

    // Three looped passes with a fresh seed captured for each.
    clear_corrupt();
    s0 = 16'($urandom); s1 = 16'($urandom); s2 = 16'($urandom);
    full_pass("loop1", s0, s1, 1'b1, 1'b1);
    full_pass("loop2", s1, s2, 1'b1, 1'b0);
    full_pass("loop3", s2, 16'h0000, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      clear_corrupt();
      repeat ($urandom_range(0, 3)) add_corrupt($urandom_range(0, cBeats - 1), $urandom_range(0, cLanes - 1));
      full_pass("random", 16'($urandom), 16'h0000, 1'b0, 1'b1);
    end

    // Watchdog: write sequencer never answers, then stalls after two bursts.
    clear_corrupt();
    start_pass(16'h5555);
    count_wr_window("wd_idle");
    start_pass(16'h6666);
    send_burst();
    send_burst();
    count_wr_window("wd_after_burst");

    // Abort at read beat 20; drain to the end of that burst (beat 31).
    start_pass(16'h0F0F);
    do_writes();
    for (int n = 0; n < 20; n++) send_beat(16'h0F0F, n);
    iRdata = beat_data(16'h0F0F, 20);
    iRvalid = 1'b1;
    iStop = 1'b1;
    tick();
    iRvalid = 1'b0;
    iStop = 1'b0;
    check_value("stop_rd_en", 32'(oRdEnable), 32'd0);
    check_value("stop_busy_drain", 32'(oBusy), 32'd1);
    for (int n = 21; n < 31; n++) send_beat(16'h0F0F, n);
    check_value("stop_busy_before_31", 32'(oBusy), 32'd1);
    send_beat(16'h0F0F, 31);
    check_value("stop_idle_after_31", 32'(oBusy), 32'd0);
    check_status("stop");
    full_pass("restart", 16'hA5A5, 16'h0000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of the read phase.
    start_pass(16'h2222);
    do_writes();
    for (int n = 0; n < 10; n++) send_beat(16'h2222, n);
    #2;
    iRST = 1'b1;
    #1;
    m_pass = 1'b0; m_fail = 1'b0; m_timeout = 1'b0; m_err = 0; m_first = 0; m_pass_cnt = 0;
    check_status("async_rst");
    check_value("async_rst_rd_en", 32'(oRdEnable), 32'd0);
    check_value("async_rst_busy", 32'(oBusy), 32'd0);
    tick();
    iRST = 1'b0;
    tick();
    full_pass("post_rst", 16'h7777, 16'h0000, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end, expected finish within 50000 cycles");
    $fatal(1);
  end

endmodule
